goal_zone: RTL and testbench
============================

# goal_zone

Parametrised goal block for the soccer-heads game: places one goal rectangle on the left or right edge of the 640×480 field and owns scoring for that goal. Once per frame, it tests the ball bounding box against the goal mouth. It debounces entry over consecutive frames and increments a saturating score. It then raises a freeze/celebration window for the game controller and the ball/player resets. It replaces the fixed-size, reset-only goal-post placement with a clocked, configurable block; the top level instantiates one per side.

## Interface
Parameters:
- GOAL_W, 72, goal width in pixels
- GOAL_H, 128, goal height in pixels
- X_MIN, 0, leftmost field pixel
- X_MAX, 639, rightmost field pixel
- Y_MAX, 460, ground line; goal bottom edge
- SCORE_W, 4, score counter width
- SCORE_MAX, 9, winning score; counter saturates here
- ENTRY_FRAMES, 2, consecutive inside frames required to count a goal (≥1)
- HOLD_FRAMES, 90, celebration/freeze length in frames (≥1)

Ports:
- frame_clk, in, 1, frame-rate clock
- Reset, in, 1, asynchronous, active-high reset
- LR, in, 1, side select: 1 = right goal, 0 = left goal; sampled at Reset and on clear_score
- clear_score, in, 1, synchronous match restart
- BallX, BallY, in, 10, ball centre
- BallS, in, 10, ball radius
- GoalX, GoalY, out, 10, goal left edge / bottom edge
- GoalSX, GoalSY, out, 10, goal width / height
- score, out, SCORE_W, goals conceded into this goal
- goal_pulse, out, 1, one-cycle strobe per counted goal
- freeze, out, 1, high during celebration
- game_over, out, 1, sticky; high once score == SCORE_MAX

## Operation
- Geometry registers:
  - GoalSX = GOAL_W, GoalSY = GOAL_H, GoalY = Y_MAX.
  - GoalX = X_MIN when LR=0; GoalX = X_MAX − GOAL_W when LR=1.
  - Loaded on Reset and on clear_score; held otherwise.
- Inside test (combinational, 11-bit unsigned arithmetic, no wrap):
  - Vertical: BallY − BallS > Y_MAX − GOAL_H. Ball top is strictly below the crossbar.
  - Left goal: BallX + BallS < GoalX + GOAL_W.
  - Right goal: BallX > GoalX + BallS, i.e. the ball's left edge is past the mouth.
  - If BallY < BallS, inside = 0.
- FSM states: ARMED, PENDING, SCORED, WAIT_CLEAR.
  - ARMED: if inside and !game_over → PENDING, cnt=1. If ENTRY_FRAMES==1, go directly to the SCORED entry action instead.
  - PENDING: if inside, cnt++; when cnt reaches ENTRY_FRAMES → SCORED. If !inside → ARMED, cnt=0.
  - SCORED entry:
    - score ← min(score+1, SCORE_MAX)
    - goal_pulse = 1 for that cycle only
    - hold=0, freeze=1
    - game_over set if the new score == SCORE_MAX
  - SCORED: hold++. At hold == HOLD_FRAMES−1 → WAIT_CLEAR, freeze=0.
  - WAIT_CLEAR: → ARMED when !inside. This blocks re-scoring while the ball sits in the net.
- clear_score (any state): score=0, game_over=0, freeze=0, cnt=hold=0, state=ARMED, geometry reloaded. Has priority over every other transition in that cycle.
- game_over: ARMED ignores inside; score holds at SCORE_MAX.

## Timing
- All state updates on posedge frame_clk. Outputs are registered; none are combinational from inputs.
- Reset values:
  - GoalX = LR ? X_MAX−GOAL_W : X_MIN; GoalY = Y_MAX; GoalSX = GOAL_W; GoalSY = GOAL_H.
  - score = 0; goal_pulse = 0; freeze = 0; game_over = 0; state ARMED.
- Latency from the first inside frame to goal_pulse: ENTRY_FRAMES edges.
- goal_pulse and the score increment occur on the same edge. freeze rises on that edge and stays high exactly HOLD_FRAMES cycles.
- Reset asserted mid-celebration returns everything to reset values immediately; no pulse is emitted.

## Structure
- Shared package game_pkg:
  - field constants (X_MIN, X_MAX, Y_MAX)
  - goal_state_t enum
  - default GOAL_W, GOAL_H
- Sub-module goal_hit_test: pure combinational inside test, shared later with crossbar collision logic.

## Test plan
- Reset with LR=1 → GoalX=567, GoalY=460, GoalSX=72, GoalSY=128, score=0, freeze=0.
- Left goal, ball (30,420,r=10) held 2 frames → goal_pulse on the 2nd edge, score=1, freeze high 90 cycles, then low.
- Ball inside 1 frame then out (ENTRY_FRAMES=2) → no pulse, score stays 0, state ARMED.
- Ball parked inside through and after celebration → exactly one goal; a second counts only after exit and re-entry.
- Nine goals → score=9, game_over=1; a tenth entry → no pulse, score stays 9; clear_score → score=0, game_over=0.
- Ball top at Y=332 (== crossbar) → not inside, no goal. Reset asserted at hold=40 → freeze=0, score=0 immediately.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: field geometry constants, default goal size, goal FSM state type
// and a helper that places a goal on the left or right field edge.
// Shared by every soccer-heads block that needs to reason about the field.
package game_pkg;

  localparam int FIELD_X_MIN = 0;
  localparam int FIELD_X_MAX = 639;
  localparam int FIELD_Y_MAX = 460;   // ground line

  localparam int GOAL_W_DEF  = 72;
  localparam int GOAL_H_DEF  = 128;

  typedef enum logic [1:0] {
    ARMED      = 2'd0,
    PENDING    = 2'd1,
    SCORED     = 2'd2,
    WAIT_CLEAR = 2'd3
  } goal_state_t;

  // Left edge of a goal: flush with x_min on the left side, and ending
  // goal_w pixels short of x_max on the right side.
  function automatic logic [9:0] goal_left_edge(input logic right, input int x_min,
                                                input int x_max, input int goal_w);
    logic [9:0] edge_x;
    if (right) begin
      edge_x = 10'(x_max - goal_w);
    end else begin
      edge_x = 10'(x_min);
    end
    return edge_x;
  endfunction

endpackage

// File: rtl/goal_hit_test.sv
// goal_hit_test: combinational test of whether the ball has entered a goal
// mouth. All arithmetic is done in 11 bits so that the 10-bit sums cannot
// wrap. The ball is inside when its top is strictly below the crossbar and
// it is fully past the mouth on the horizontal axis.
//
// Ports:
//   ball_x_i, ball_y_i  ball centre
//   ball_s_i            ball radius
//   goal_x_i            goal left edge
//   right_i             1 = goal on the right edge, 0 = left edge
//   inside_o            ball is inside the goal
module goal_hit_test #(
  parameter int GOAL_W = 72,
  parameter int GOAL_H = 128,
  parameter int Y_MAX  = 460
) (
  input  logic [9:0] ball_x_i,
  input  logic [9:0] ball_y_i,
  input  logic [9:0] ball_s_i,
  input  logic [9:0] goal_x_i,
  input  logic       right_i,
  output logic       inside_o
);

  localparam logic [10:0] CROSSBAR_Y = 11'(Y_MAX - GOAL_H);
  localparam logic [10:0] GOAL_W_11  = 11'(GOAL_W);

  logic [10:0] bx_s;
  logic [10:0] by_s;
  logic [10:0] bs_s;
  logic [10:0] gx_s;
  logic        vert_ok_s;
  logic        left_ok_s;
  logic        right_ok_s;

  // Zero-extend and evaluate the three edge tests.
  always_comb begin
    bx_s = {1'b0, ball_x_i};
    by_s = {1'b0, ball_y_i};
    bs_s = {1'b0, ball_s_i};
    gx_s = {1'b0, goal_x_i};
    // A ball poking above the top of the screen would make by-bs wrap;
    // treat it as not inside.
    vert_ok_s  = (by_s >= bs_s) && ((by_s - bs_s) > CROSSBAR_Y);
    left_ok_s  = (bx_s + bs_s) < (gx_s + GOAL_W_11);
    right_ok_s = bx_s > (gx_s + bs_s);
    if (right_i) begin
      inside_o = vert_ok_s && right_ok_s;
    end else begin
      inside_o = vert_ok_s && left_ok_s;
    end
  end

endmodule

// File: rtl/goal_zone.sv
// goal_zone: one goal of the soccer-heads field. Places the goal rectangle on
// the left or right edge, samples the ball once per frame, debounces entry
// over ENTRY_FRAMES consecutive frames, counts a saturating score and raises
// a HOLD_FRAMES-long freeze window after each counted goal.
//
// Ports:
//   frame_clk              frame-rate clock
//   Reset                  asynchronous active-high reset
//   LR                     side select (1 = right), sampled at Reset/clear_score
//   clear_score            synchronous match restart
//   BallX, BallY, BallS    ball centre and radius
//   GoalX, GoalY           goal left edge / bottom edge
//   GoalSX, GoalSY         goal width / height
//   score                  goals conceded into this goal
//   goal_pulse             one-cycle strobe per counted goal
//   freeze                 high during celebration
//   game_over              sticky, set when score reaches SCORE_MAX
module goal_zone
  import game_pkg::*;
#(
  parameter int GOAL_W       = GOAL_W_DEF,
  parameter int GOAL_H       = GOAL_H_DEF,
  parameter int X_MIN        = FIELD_X_MIN,
  parameter int X_MAX        = FIELD_X_MAX,
  parameter int Y_MAX        = FIELD_Y_MAX,
  parameter int SCORE_W      = 4,
  parameter int SCORE_MAX    = 9,
  parameter int ENTRY_FRAMES = 2,
  parameter int HOLD_FRAMES  = 90
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               LR,
  input  logic               clear_score,
  input  logic [9:0]         BallX,
  input  logic [9:0]         BallY,
  input  logic [9:0]         BallS,
  output logic [9:0]         GoalX,
  output logic [9:0]         GoalY,
  output logic [9:0]         GoalSX,
  output logic [9:0]         GoalSY,
  output logic [SCORE_W-1:0] score,
  output logic               goal_pulse,
  output logic               freeze,
  output logic               game_over
);

  localparam int CNT_W  = (ENTRY_FRAMES > 1) ? $clog2(ENTRY_FRAMES + 1) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ENTRY_FRAMES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  goal_state_t        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               lr_q;
  logic [9:0]         goal_x_q;
  logic [SCORE_W-1:0] score_q;
  logic               pulse_q;
  logic               freeze_q;
  logic               over_q;

  logic               inside_s;
  logic               enter_scored_s;
  logic [SCORE_W-1:0] score_inc_s;

  goal_hit_test #(
    .GOAL_W (GOAL_W),
    .GOAL_H (GOAL_H),
    .Y_MAX  (Y_MAX)
  ) u_hit (
    .ball_x_i (BallX),
    .ball_y_i (BallY),
    .ball_s_i (BallS),
    .goal_x_i (goal_x_q),
    .right_i  (lr_q),
    .inside_o (inside_s)
  );

  // Saturating score increment.
  always_comb begin
    if (score_q >= SCORE_TOP) begin
      score_inc_s = SCORE_TOP;
    end else begin
      score_inc_s = score_q + SCORE_W'(1);
    end
  end

  // A goal is counted on the edge that completes the entry debounce; with a
  // one-frame debounce this happens straight from ARMED.
  always_comb begin
    enter_scored_s = 1'b0;
    case (state_q)
      ARMED:   enter_scored_s = inside_s && !over_q && (ENTRY_FRAMES == 1);
      PENDING: enter_scored_s = inside_s && ((cnt_q + CNT_W'(1)) == CNT_LAST);
      default: enter_scored_s = 1'b0;
    endcase
  end

  // Goal FSM, score, freeze window and geometry registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ARMED;
      cnt_q    <= '0;
      hold_q   <= '0;
      lr_q     <= LR;
      goal_x_q <= goal_left_edge(LR, X_MIN, X_MAX, GOAL_W);
      score_q  <= '0;
      pulse_q  <= 1'b0;
      freeze_q <= 1'b0;
      over_q   <= 1'b0;
    end else if (clear_score) begin
      state_q  <= ARMED;
      cnt_q    <= '0;
      hold_q   <= '0;
      lr_q     <= LR;
      goal_x_q <= goal_left_edge(LR, X_MIN, X_MAX, GOAL_W);
      score_q  <= '0;
      pulse_q  <= 1'b0;
      freeze_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (enter_scored_s) begin
        state_q  <= SCORED;
        cnt_q    <= '0;
        hold_q   <= '0;
        score_q  <= score_inc_s;
        pulse_q  <= 1'b1;
        freeze_q <= 1'b1;
        over_q   <= over_q | (score_inc_s == SCORE_TOP);
      end else begin
        case (state_q)
          ARMED: begin
            if (inside_s && !over_q) begin
              state_q <= PENDING;
              cnt_q   <= CNT_W'(1);
            end
          end
          PENDING: begin
            if (inside_s) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              state_q <= ARMED;
              cnt_q   <= '0;
            end
          end
          SCORED: begin
            // freeze rose on the entry edge; it drops after HOLD_FRAMES cycles.
            if (hold_q == HOLD_LAST) begin
              state_q  <= WAIT_CLEAR;
              hold_q   <= '0;
              freeze_q <= 1'b0;
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
          WAIT_CLEAR: begin
            // The ball must leave the net before another goal can count.
            if (!inside_s) begin
              state_q <= ARMED;
            end
          end
          default: begin
            state_q <= ARMED;
          end
        endcase
      end
    end
  end

  assign GoalX      = goal_x_q;
  // Height, width and bottom edge never change for a given instance.
  assign GoalY      = 10'(Y_MAX);
  assign GoalSX     = 10'(GOAL_W);
  assign GoalSY     = 10'(GOAL_H);
  assign score      = score_q;
  assign goal_pulse = pulse_q;
  assign freeze     = freeze_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_goal_zone.sv
// Testbench for goal_zone with default parameters. A behavioural model
// (goal streak counter, frames-of-freeze-left countdown, "ball must leave"
// flag) predicts score/goal_pulse/freeze/game_over every frame.
module tb_goal_zone;

  localparam int EF   = 2;
  localparam int HF   = 90;
  localparam int SMAX = 9;
  localparam int RGX  = 639 - 72;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       LR;
  logic       clear_score;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallS;
  logic [9:0] GoalX;
  logic [9:0] GoalY;
  logic [9:0] GoalSX;
  logic [9:0] GoalSY;
  logic [3:0] score;
  logic       goal_pulse;
  logic       freeze;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  // model state
  int m_score;
  int m_streak;
  int m_freeze_left;
  bit m_over;
  bit m_pulse;
  bit m_need_exit;
  bit m_lr;

  goal_zone dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .LR          (LR),
    .clear_score (clear_score),
    .BallX       (BallX),
    .BallY       (BallY),
    .BallS       (BallS),
    .GoalX       (GoalX),
    .GoalY       (GoalY),
    .GoalSX      (GoalSX),
    .GoalSY      (GoalSY),
    .score       (score),
    .goal_pulse  (goal_pulse),
    .freeze      (freeze),
    .game_over   (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic bit ref_inside(input int bx, input int by, input int bs, input bit right);
    int gx;
    gx = right ? RGX : 0;
    if (by < bs) return 1'b0;
    if (by - bs <= 460 - 128) return 1'b0;
    if (right) return bx > gx + bs;
    return bx + bs < gx + 72;
  endfunction

  task automatic model_clear(input bit lr);
    m_lr = lr; m_score = 0; m_streak = 0; m_freeze_left = 0;
    m_over = 0; m_pulse = 0; m_need_exit = 0;
  endtask

  task automatic model_step(input bit in, input bit clr);
    if (clr) begin
      model_clear(LR);
      return;
    end
    m_pulse = 0;
    if (m_freeze_left > 0) begin
      m_freeze_left--;
      if (m_freeze_left == 0) m_need_exit = 1;
    end else if (m_need_exit) begin
      if (!in) m_need_exit = 0;
    end else if (in && (m_streak > 0 || !m_over)) begin
      m_streak++;
      if (m_streak >= EF) begin
        m_streak = 0;
        m_pulse = 1;
        m_freeze_left = HF;
        if (m_score < SMAX) m_score++;
        if (m_score == SMAX) m_over = 1;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  function automatic logic [16:0] model_out();
    logic [9:0] gx;
    logic [3:0] sc;
    gx = m_lr ? 10'(RGX) : 10'd0;
    sc = 4'(m_score);
    return {gx, sc, m_pulse, (m_freeze_left > 0), m_over};
  endfunction

  task automatic tick(input int bx, input int by, input int bs, input bit clr);
    BallX = 10'(bx); BallY = 10'(by); BallS = 10'(bs); clear_score = clr;
    @(posedge frame_clk);
    model_step(ref_inside(bx, by, bs, m_lr), clr);
    #1;
    clear_score = 1'b0;
  endtask

  task automatic do_reset(input bit lr);
    LR = lr; clear_score = 1'b0;
    BallX = 10'd320; BallY = 10'd200; BallS = 10'd10;
    Reset = 1'b1;
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    model_clear(lr);
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++;
    if ({GoalX, GoalY, GoalSX, GoalSY} !== {10'd567, 10'd460, 10'd72, 10'd128}) begin
      errors++;
      $display("FAIL reset_geom got=%0d,%0d,%0d,%0d exp=567,460,72,128", GoalX, GoalY, GoalSX, GoalSY);
    end
    checks++;
    if ({score, goal_pulse, freeze, game_over} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outs got score=%0d pulse=%b freeze=%b over=%b exp all 0",
               score, goal_pulse, freeze, game_over);
    end
  endtask

  task automatic test_single_goal();
    int fcount;
    do_reset(1'b0);
    checks++;
    if (GoalX !== 10'd0) begin
      errors++;
      $display("FAIL left_goalx got=%0d exp=0", GoalX);
    end
    for (int i = 0; i < 2; i++) begin
      tick(30, 420, 10, 1'b0);
      checks++;
      if ({goal_pulse, score} !== {(i == 1), ((i == 1) ? 4'd1 : 4'd0)}) begin
        errors++;
        $display("FAIL single_entry edge=%0d got pulse=%b score=%0d exp pulse=%b", i + 1, goal_pulse, score, (i == 1));
      end
    end
    fcount = freeze ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      tick(320, 200, 10, 1'b0);
      checks++;
      if ({GoalX, score, goal_pulse, freeze, game_over} !== model_out()) begin
        errors++;
        $display("FAIL single_hold cyc=%0d got=%b exp=%b", i, {GoalX, score, goal_pulse, freeze, game_over}, model_out());
      end
      if (freeze) fcount++;
    end
    checks++;
    if (fcount != HF) begin
      errors++;
      $display("FAIL freeze_len got=%0d exp=%0d", fcount, HF);
    end
  endtask

  task automatic test_short_entry();
    do_reset(1'b0);
    tick(30, 420, 10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(320, 200, 10, 1'b0);
      checks++;
      if ({score, goal_pulse, freeze} !== 6'd0) begin
        errors++;
        $display("FAIL short_entry cyc=%0d got score=%0d pulse=%b freeze=%b exp 0", i, score, goal_pulse, freeze);
      end
    end
    // Back in ARMED: a fresh two-frame entry must count on its 2nd edge.
    tick(30, 420, 10, 1'b0);
    tick(30, 420, 10, 1'b0);
    checks++;
    if ({goal_pulse, score} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL short_rearm got pulse=%b score=%0d exp pulse=1 score=1", goal_pulse, score);
    end
  endtask

  task automatic test_parked();
    int pulses;
    do_reset(1'b0);
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      tick(30, 420, 10, 1'b0);
      checks++;
      if ({GoalX, score, goal_pulse, freeze, game_over} !== model_out()) begin
        errors++;
        $display("FAIL parked cyc=%0d got=%b exp=%b", i, {GoalX, score, goal_pulse, freeze, game_over}, model_out());
      end
      if (goal_pulse) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL parked_pulses got=%0d exp=1", pulses);
    end
    tick(320, 200, 10, 1'b0);
    tick(30, 420, 10, 1'b0);
    tick(30, 420, 10, 1'b0);
    checks++;
    if ({goal_pulse, score} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL parked_reentry got pulse=%b score=%0d exp pulse=1 score=2", goal_pulse, score);
    end
  endtask

  task automatic test_game_over();
    do_reset(1'b0);
    for (int g = 0; g < SMAX; g++) begin
      for (int i = 0; i < 94; i++) begin
        if (i < 2) tick(30, 420, 10, 1'b0);
        else tick(320, 200, 10, 1'b0);
        checks++;
        if ({GoalX, score, goal_pulse, freeze, game_over} !== model_out()) begin
          errors++;
          $display("FAIL nine_goals g=%0d cyc=%0d got=%b exp=%b", g, i, {GoalX, score, goal_pulse, freeze, game_over}, model_out());
        end
      end
    end
    checks++;
    if ({score, game_over} !== {4'd9, 1'b1}) begin
      errors++;
      $display("FAIL game_over got score=%0d over=%b exp score=9 over=1", score, game_over);
    end
    for (int i = 0; i < 10; i++) begin
      tick(30, 420, 10, 1'b0);
      checks++;
      if ({goal_pulse, score, game_over} !== {1'b0, 4'd9, 1'b1}) begin
        errors++;
        $display("FAIL tenth_entry cyc=%0d got pulse=%b score=%0d over=%b exp 0,9,1", i, goal_pulse, score, game_over);
      end
    end
    LR = 1'b1;
    tick(30, 420, 10, 1'b1);
    checks++;
    if ({score, game_over, freeze, GoalX} !== {4'd0, 1'b0, 1'b0, 10'd567}) begin
      errors++;
      $display("FAIL clear_score got score=%0d over=%b freeze=%b goalx=%0d exp 0,0,0,567", score, game_over, freeze, GoalX);
    end
  endtask

  task automatic test_boundaries();
    int cx[7] = '{30, 30, 62, 61, 5, 577, 578};
    int cy[7] = '{342, 343, 420, 420, 5, 420, 420};
    bit cl[7] = '{0, 0, 0, 0, 0, 1, 1};
    bit cg[7] = '{0, 1, 0, 1, 0, 0, 1};
    int pulses;
    for (int k = 0; k < 7; k++) begin
      do_reset(cl[k]);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
        tick(cx[k], cy[k], 10, 1'b0);
        if (goal_pulse) pulses++;
      end
      checks++;
      if (pulses != int'(cg[k])) begin
        errors++;
        $display("FAIL boundary case=%0d ball=(%0d,%0d,10) lr=%0d got pulses=%0d exp=%0d", k, cx[k], cy[k], cl[k], pulses, cg[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    tick(30, 420, 10, 1'b0);
    tick(30, 420, 10, 1'b0);
    for (int i = 0; i < 40; i++) tick(320, 200, 10, 1'b0);
    checks++;
    if ({freeze, score} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL mid_pre got freeze=%b score=%0d exp freeze=1 score=1", freeze, score);
    end
    Reset = 1'b1;
    #2;
    checks++;
    if ({freeze, score, goal_pulse, game_over} !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset got freeze=%b score=%0d pulse=%b exp all 0", freeze, score, goal_pulse);
    end
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    model_clear(LR);
    tick(320, 200, 10, 1'b0);
    checks++;
    if ({GoalX, score, goal_pulse, freeze, game_over} !== model_out()) begin
      errors++;
      $display("FAIL mid_after got=%b exp=%b", {GoalX, score, goal_pulse, freeze, game_over}, model_out());
    end
  endtask

  task automatic test_random();
    int bx, by, bs;
    bit clr;
    do_reset(1'($urandom_range(0, 1)));
    bx = 320; by = 200; bs = 10;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bx = m_lr ? int'($urandom_range(540, 639)) : int'($urandom_range(0, 100));
        by = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 479)) : int'($urandom_range(300, 479));
        bs = $urandom_range(0, 40);
      end
      clr = ($urandom_range(0, 399) == 0);
      if (clr || $urandom_range(0, 49) == 0) LR = 1'($urandom_range(0, 1));
      tick(bx, by, bs, clr);
      checks++;
      if ({GoalX, score, goal_pulse, freeze, game_over} !== model_out()) begin
        errors++;
        $display("FAIL random cyc=%0d ball=(%0d,%0d,%0d) got=%b exp=%b", i, bx, by, bs,
                 {GoalX, score, goal_pulse, freeze, game_over}, model_out());
      end
    end
  endtask

  initial begin
    Reset = 1'b1; LR = 1'b1; clear_score = 1'b0;
    BallX = 10'd320; BallY = 10'd200; BallS = 10'd10;
    test_reset();
    test_single_goal();
    test_short_entry();
    test_parked();
    test_game_over();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
